// File: rtl/loctag_pkg.sv
// Shared ADC frame geometry and emulator FSM states, also used by the ADC reader.
package loctag_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } adc_state_t;

endpackage

// File: rtl/adc_emu_sync_edge.sv
// Synchronizes one asynchronous pin and emits registered single-cycle rise/fall pulses.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   settle;

  // Edges stay masked until the chain has flushed after reset, so a pin that
  // already differs from RESET_VAL is not reported as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain  <= {STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
      settle <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      chain  <= (chain << 1) | STAGES'(din);
      prev   <= chain[STAGES-1];
      settle <= {settle[STAGES-1:0], 1'b1};
      rise   <= settle[STAGES] & chain[STAGES-1] & ~prev;
      fall   <= settle[STAGES] & ~chain[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/adc_emu.sv
// Serial ADC emulator: shifts a zero-padded sample out on adc_so under reader-driven CS/SCLK.
module adc_emu
  import loctag_pkg::*;
#(
  parameter int DATA_BITS   = ADC_DATA_BITS,
  parameter int LEAD_ZEROS  = ADC_FRAME_BITS - ADC_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_cs,
  input  logic                 adc_clk,
  output logic                 adc_so,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 underrun,
  output logic [15:0]          frame_count
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  adc_state_t            state, next_state;
  logic                  cs_rise, cs_fall, clk_fall, clk_rise_unused;
  logic                  hold_full, transfer;
  logic                  start_evt, done_evt, abort_evt, shift_evt;
  logic [DATA_BITS-1:0]  hold_data, last_sample, load_value;
  logic [FRAME_BITS-1:0] load_frame, shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [15:0]           count_q;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (adc_cs),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // The reader samples on rising SCLK edges, so only falling edges advance the frame.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (adc_clk),
    .rise  (clk_rise_unused),
    .fall  (clk_fall)
  );

  assign sample_ready = ~hold_full;
  assign transfer     = sample_valid & sample_ready;
  assign load_value   = hold_full ? hold_data : (transfer ? sample_data : last_sample);
  assign load_frame   = FRAME_BITS'(load_value);
  assign frame_count  = count_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // CS rise wins over a coincident SCLK fall, so that case resolves as an abort.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (cs_fall) next_state = SHIFT;
      SHIFT: begin
        if (cs_rise)
          next_state = IDLE;
        else if (clk_fall && bit_cnt == CNT_W'(FRAME_BITS))
          next_state = DONE;
      end
      DONE:    if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    start_evt = (state == IDLE) && cs_fall;
    done_evt  = (state == SHIFT) && (next_state == DONE);
    abort_evt = (state == SHIFT) && (next_state == IDLE);
    shift_evt = (state == SHIFT) && (next_state == SHIFT) && clk_fall;
  end

  // bit_cnt counts frame bits already presented on adc_so.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full   <= 1'b0;
      hold_data   <= '0;
      last_sample <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      adc_so      <= 1'b0;
      count_q     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= done_evt;
      frame_abort <= abort_evt;
      underrun    <= start_evt && !hold_full && !transfer;
      if (done_evt)
        count_q <= count_q + 16'd1;

      if (start_evt) begin
        last_sample <= load_value;
        hold_full   <= 1'b0;
      end else if (transfer) begin
        hold_data <= sample_data;
        hold_full <= 1'b1;
      end

      if (start_evt) begin
        adc_so  <= load_frame[FRAME_BITS-1];
        shreg   <= load_frame << 1;
        bit_cnt <= CNT_W'(1);
      end else if (shift_evt) begin
        adc_so  <= shreg[FRAME_BITS-1];
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (next_state != SHIFT) begin
        adc_so <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_emu.sv
// Randomized reader-side bench for adc_emu with a transaction-level model of hold/frame rules.
module tb_adc_emu;

  logic        clk, reset, adc_cs, adc_clk, adc_so;
  logic        sample_valid, sample_ready, busy;
  logic        frame_done, frame_abort, underrun;
  logic [11:0] sample_data;
  logic [15:0] frame_count;

  int tests, fails;
  int done_seen, abort_seen, under_seen;
  bit chk_en;

  bit          m_hold_full, m_busy;
  logic [11:0] m_hold, m_last;
  logic [15:0] m_count;

  adc_emu dut (
    .clk          (clk),
    .reset        (reset),
    .adc_cs       (adc_cs),
    .adc_clk      (adc_clk),
    .adc_so       (adc_so),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .underrun     (underrun),
    .frame_count  (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Pulse counters; stimulus compares before/after snapshots.
  always @(negedge clk) begin
    if (frame_done === 1'b1)  done_seen++;
    if (frame_abort === 1'b1) abort_seen++;
    if (underrun === 1'b1)    under_seen++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] data);
    chk_en = 1'b0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = data;
    if (!m_hold_full) begin
      m_hold      = data;
      m_hold_full = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    sample_data  = '0;
    chk_en = 1'b1;
  endtask

  task automatic half_period();
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input int n_falls, input bit bypass, input logic [11:0] byp_data,
                           output logic [15:0] cap);
    logic [15:0] exp_word, mask;
    bit          exp_under;
    int          d0, a0, u0;
    cap = '0;
    chk_en = 1'b0;
    d0 = done_seen; a0 = abort_seen; u0 = under_seen;
    if (m_hold_full) begin
      exp_word = {4'h0, m_hold}; m_hold_full = 1'b0; exp_under = 1'b0;
    end else if (bypass) begin
      exp_word = {4'h0, byp_data}; exp_under = 1'b0;
    end else begin
      exp_word = {4'h0, m_last}; exp_under = 1'b1;
    end
    m_last = exp_word[11:0];

    @(negedge clk);
    adc_cs = 1'b0;
    if (bypass) begin
      repeat (3) @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = byp_data;
      @(negedge clk);
      sample_valid = 1'b0;
      sample_data  = '0;
      repeat (4) @(negedge clk);
    end else begin
      half_period();
    end
    m_busy = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < n_falls; i++) begin
      cap[15-i] = adc_so;
      adc_clk = 1'b1;
      half_period();
      if (i == 15) chk_en = 1'b0;
      adc_clk = 1'b0;
      half_period();
    end

    if (n_falls == 16) begin
      m_count = m_count + 16'd1;
      chk_en = 1'b1;
      checkOutput("so_in_done", 32'(adc_so), 32'h0);
      repeat (2) @(negedge clk);
    end
    chk_en = 1'b0;
    adc_cs = 1'b1;
    half_period();
    m_busy = 1'b0;
    chk_en = 1'b1;

    mask = 16'hFFFF;
    mask = ~(mask >> n_falls);
    checkOutput("frame_bits", 32'(cap & mask), 32'(exp_word & mask));
    checkOutput("done_pulses", 32'(done_seen - d0), (n_falls == 16) ? 32'd1 : 32'd0);
    checkOutput("abort_pulses", 32'(abort_seen - a0), (n_falls == 16) ? 32'd0 : 32'd1);
    checkOutput("underrun_pulses", 32'(under_seen - u0), 32'(exp_under));
  endtask

  task automatic reset_mid_frame();
    int a0;
    chk_en = 1'b0;
    a0 = abort_seen;
    @(negedge clk);
    adc_cs = 1'b0;
    half_period();
    for (int i = 0; i < 9; i++) begin
      adc_clk = 1'b1;
      half_period();
      adc_clk = 1'b0;
      half_period();
    end
    checkOutput("busy_before_reset", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("so_after_reset", 32'(adc_so), 32'h0);
    checkOutput("busy_after_reset", 32'(busy), 32'h0);
    checkOutput("abort_after_reset", 32'(frame_abort), 32'h0);
    m_hold_full = 1'b0; m_last = '0; m_count = '0; m_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adc_clk = 1'b1;
      half_period();
      adc_clk = 1'b0;
      half_period();
    end
    checkOutput("busy_cs_still_low", 32'(busy), 32'h0);
    checkOutput("no_abort_on_reset", 32'(abort_seen - a0), 32'h0);
    adc_cs = 1'b1;
    half_period();
    chk_en = 1'b1;
  endtask

  initial begin
    logic [15:0] word;
    int u0, d0;
    reset = 1'b1; adc_cs = 1'b1; adc_clk = 1'b0;
    sample_valid = 1'b0; sample_data = '0; chk_en = 1'b0;
    m_hold_full = 1'b0; m_busy = 1'b0; m_hold = '0; m_last = '0; m_count = '0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
          checkOutput("sample_ready", 32'(sample_ready), 32'(!m_hold_full));
          checkOutput("busy", 32'(busy), 32'(m_busy));
          checkOutput("frame_count", 32'(frame_count), 32'(m_count));
        end
      end
    join_none

    repeat (4) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_ready", 32'(sample_ready), 32'h1);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_so", 32'(adc_so), 32'h0);
    checkOutput("reset_count", 32'(frame_count), 32'h0);
    checkOutput("reset_underrun", 32'(underrun), 32'h0);
    repeat (6) @(negedge clk);
    chk_en = 1'b1;

    d0 = done_seen;
    applyStimulus(12'hABC);
    run_frame(16, 1'b0, '0, word);
    checkOutput("frame_abc", 32'(word), 32'h0ABC);
    checkOutput("count_after_abc", 32'(frame_count), 32'h1);
    checkOutput("done_once_abc", 32'(done_seen - d0), 32'h1);

    run_frame(7, 1'b0, '0, word);
    checkOutput("count_after_abort", 32'(frame_count), 32'h1);
    applyStimulus(12'h123);
    run_frame(16, 1'b0, '0, word);
    checkOutput("frame_123", 32'(word), 32'h0123);

    applyStimulus(12'h555);
    run_frame(16, 1'b0, '0, word);
    u0 = under_seen;
    run_frame(16, 1'b0, '0, word);
    checkOutput("frame_555_reuse", 32'(word), 32'h0555);
    checkOutput("underrun_once", 32'(under_seen - u0), 32'h1);

    run_frame(16, 1'b1, 12'hFFF, word);
    checkOutput("frame_bypass", 32'(word), 32'h0FFF);
    checkOutput("ready_after_bypass", 32'(sample_ready), 32'h1);

    reset_mid_frame();
    applyStimulus(12'h2A5);
    run_frame(16, 1'b0, '0, word);
    checkOutput("frame_after_reset", 32'(word), 32'h02A5);
    checkOutput("count_after_reset", 32'(frame_count), 32'h1);

    chk_en = 1'b0;
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    m_count = 16'hFFFF;
    chk_en = 1'b1;
    run_frame(16, 1'b0, '0, word);
    checkOutput("count_wrap", 32'(frame_count), 32'h0);

    for (int it = 0; it < 20; it++) begin
      int kind;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 2) != 0) applyStimulus(12'($urandom));
      if ($urandom_range(0, 3) == 0) applyStimulus(12'($urandom));
      kind = $urandom_range(0, 9);
      if (kind < 2)
        run_frame($urandom_range(1, 15), 1'b0, '0, word);
      else if (kind == 2 && !m_hold_full)
        run_frame(16, 1'b1, 12'($urandom), word);
      else
        run_frame(16, 1'b0, '0, word);
    end

    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
